// File: rtl/rop_pkg.sv
// Shared types and helpers for the ROP write-merge buffer.
package rop_pkg;

  localparam int unsigned WADDR_W = 30;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned STRB_W  = 4;

  typedef struct packed {
    logic               valid;
    logic [WADDR_W-1:0] waddr;
    logic [DATA_W-1:0]  data;
    logic [STRB_W-1:0]  strb;
  } wmb_entry_t;

  typedef enum logic {
    WMB_IDLE = 1'b0,
    WMB_SEND = 1'b1
  } wmb_state_t;

  // Replace each byte lane of old_data whose strobe is set with new_data's lane.
  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_data,
    input logic [DATA_W-1:0] new_data,
    input logic [STRB_W-1:0] strb
  );
    logic [DATA_W-1:0] res;
    res = old_data;
    for (int i = 0; i < STRB_W; i++) begin
      if (strb[i]) res[8*i +: 8] = new_data[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/rop_wmb_match.sv
// Combinational word-address match over the buffer entries; locked entries never hit.
module rop_wmb_match
  import rop_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  wmb_entry_t         entries [DEPTH],
  input  logic [DEPTH-1:0]   lock,
  input  logic [WADDR_W-1:0] waddr,
  output logic [DEPTH-1:0]   hit,
  output logic               hit_any
);

  always_comb begin
    hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit[i] = entries[i].valid && !lock[i] && (entries[i].waddr == waddr);
    end
  end

  assign hit_any = |hit;

endmodule

// File: rtl/rop_wmb.sv
// Write-merge buffer: merges byte-strobed stores per word and drains them in
// allocation order as full-word memory writes with accumulated strobes.
module rop_wmb
  import rop_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned DRAIN_THRESH = 2,
  parameter int unsigned IDLE_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_wdata,
  input  logic [3:0]  st_wstrb,
  output logic        st_ready,
  input  logic        drain_req,
  output logic        mem_wr_valid,
  output logic [31:0] mem_wr_addr,
  output logic [31:0] mem_wr_data,
  output logic [3:0]  mem_wr_strb,
  input  logic        mem_wr_ready,
  output logic        empty,
  output logic        busy
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned IDLE_W = (IDLE_TIMEOUT < 1) ? 1 : $clog2(IDLE_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  THRESH_C = CNT_W'(DRAIN_THRESH);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_TIMEOUT);

  wmb_entry_t        entries_q [DEPTH];
  wmb_entry_t        entries_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  wmb_state_t        state_q, state_d;
  logic [DEPTH-1:0]  lock, hit;
  logic              hit_any, accept, alloc, pop;
  logic              cond_now, cond_next, out_empty;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = ^st_addr[1:0];

  // Head is locked while its write is being presented.
  always_comb begin
    lock = '0;
    if (state_q == WMB_SEND) lock[head_q] = 1'b1;
  end

  rop_wmb_match #(.DEPTH(DEPTH)) u_match (
    .entries (entries_q),
    .lock    (lock),
    .waddr   (st_addr[31:2]),
    .hit     (hit),
    .hit_any (hit_any)
  );

  assign st_ready = hit_any || (count_q < DEPTH_C);
  assign accept   = st_valid && st_ready;
  assign alloc    = accept && !hit_any && (st_wstrb != '0);
  assign pop      = (state_q == WMB_SEND) && mem_wr_ready;

  // Entry array update: merge, pop, allocate (never the same slot).
  always_comb begin
    entries_d = entries_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (accept && hit[i]) begin
        entries_d[i].data = merge_bytes(entries_q[i].data, st_wdata, st_wstrb);
        entries_d[i].strb = entries_q[i].strb | st_wstrb;
      end
    end
    if (pop) entries_d[head_q].valid = 1'b0;
    if (alloc) begin
      entries_d[tail_q].valid = 1'b1;
      entries_d[tail_q].waddr = st_addr[31:2];
      entries_d[tail_q].data  = merge_bytes(32'd0, st_wdata, st_wstrb);
      entries_d[tail_q].strb  = st_wstrb;
    end
  end

  // Pointers, occupancy, idle timer and drain FSM next state.
  always_comb begin
    head_d  = head_q + PTR_W'(pop);
    tail_d  = tail_q + PTR_W'(alloc);
    count_d = count_q + CNT_W'(alloc) - CNT_W'(pop);
    idle_d  = idle_q;
    if (accept || (count_q == '0)) idle_d = '0;
    else if (idle_q != IDLE_MAX)   idle_d = idle_q + IDLE_W'(1);

    cond_now  = (count_q != '0) &&
                ((count_q >= THRESH_C) || (idle_q == IDLE_MAX) || drain_req);
    cond_next = (count_d != '0) &&
                ((count_d >= THRESH_C) || (idle_d == IDLE_MAX) || drain_req);

    state_d = state_q;
    case (state_q)
      WMB_IDLE: if (cond_now) state_d = WMB_SEND;
      WMB_SEND: if (pop && !cond_next) state_d = WMB_IDLE;
      default:  state_d = WMB_IDLE;
    endcase

    out_empty = (count_d == '0) && (state_d == WMB_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= WMB_IDLE;
    else     state_q <= state_d;
  end

  // Storage plus registered write channel, loaded from the next head entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      idle_q       <= '0;
      mem_wr_valid <= 1'b0;
      mem_wr_addr  <= '0;
      mem_wr_data  <= '0;
      mem_wr_strb  <= '0;
      empty        <= 1'b1;
      busy         <= 1'b0;
    end else begin
      entries_q    <= entries_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      idle_q       <= idle_d;
      mem_wr_valid <= (state_d == WMB_SEND);
      mem_wr_addr  <= (state_d == WMB_SEND) ? {entries_d[head_d].waddr, 2'b00} : '0;
      mem_wr_data  <= (state_d == WMB_SEND) ? entries_d[head_d].data : '0;
      mem_wr_strb  <= (state_d == WMB_SEND) ? entries_d[head_d].strb : '0;
      empty        <= out_empty;
      busy         <= !out_empty;
    end
  end

endmodule

// File: tb/tb_rop_wmb.sv
// Self-checking bench for rop_wmb: queue-based reference model plus directed scenarios.
module tb_rop_wmb;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned THRESH = 2;
  localparam int unsigned TO     = 15;

  logic        clk;
  logic        rst;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic        st_ready;
  logic        drain_req;
  logic        mem_wr_valid;
  logic [31:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic [3:0]  mem_wr_strb;
  logic        mem_wr_ready;
  logic        empty;
  logic        busy;

  rop_wmb #(.DEPTH(DEPTH), .DRAIN_THRESH(THRESH), .IDLE_TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .st_valid     (st_valid),
    .st_addr      (st_addr),
    .st_wdata     (st_wdata),
    .st_wstrb     (st_wstrb),
    .st_ready     (st_ready),
    .drain_req    (drain_req),
    .mem_wr_valid (mem_wr_valid),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_wr_strb  (mem_wr_strb),
    .mem_wr_ready (mem_wr_ready),
    .empty        (empty),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: ordered list of buffered words plus a "presenting" flag.
  typedef struct {
    logic [29:0] waddr;
    logic [31:0] data;
    logic [3:0]  strb;
  } ment_t;

  ment_t mq[$];
  ment_t wlog[$];
  bit    m_send = 1'b0;
  int    m_idle = 0;

  function automatic int m_hit(input logic [31:0] a);
    for (int i = 0; i < mq.size(); i++)
      if (mq[i].waddr == a[31:2] && !(m_send && i == 0)) return i;
    return -1;
  endfunction

  function automatic bit m_ready();
    return (m_hit(st_addr) >= 0) || (mq.size() < int'(DEPTH));
  endfunction

  task automatic model_step();
    int    cnt0, cnt1, h, idle_n;
    bit    acc, pop, cond_now;
    ment_t e;
    if (rst) begin
      mq.delete();
      m_send = 1'b0;
      m_idle = 0;
      return;
    end
    cnt0     = mq.size();
    h        = m_hit(st_addr);
    acc      = st_valid && ((h >= 0) || (cnt0 < int'(DEPTH)));
    pop      = m_send && mem_wr_ready;
    cond_now = (cnt0 > 0) && (cnt0 >= int'(THRESH) || m_idle == int'(TO) || drain_req);
    idle_n   = (acc || cnt0 == 0) ? 0 : ((m_idle + 1 > int'(TO)) ? int'(TO) : m_idle + 1);
    if (acc && h >= 0) begin
      e = mq[h];
      for (int l = 0; l < 4; l++) if (st_wstrb[l]) e.data[8*l +: 8] = st_wdata[8*l +: 8];
      e.strb = e.strb | st_wstrb;
      mq[h] = e;
    end else if (acc && st_wstrb != 4'd0) begin
      e.waddr = st_addr[31:2];
      e.data  = 32'd0;
      for (int l = 0; l < 4; l++) if (st_wstrb[l]) e.data[8*l +: 8] = st_wdata[8*l +: 8];
      e.strb  = st_wstrb;
      mq.push_back(e);
    end
    if (pop) void'(mq.pop_front());
    cnt1 = mq.size();
    if (!m_send) m_send = cond_now;
    else if (pop) m_send = (cnt1 > 0) && (cnt1 >= int'(THRESH) || idle_n == int'(TO) || drain_req);
    m_idle = idle_n;
  endtask

  logic [31:0] e_addr, e_data;
  logic [3:0]  e_strb;
  bit          e_empty;
  ment_t       lg;

  // Per-cycle comparison against the model, then advance the model.
  always @(negedge clk) begin
    if (chk_en) begin
      e_addr  = (m_send && mq.size() > 0) ? {mq[0].waddr, 2'b00} : 32'd0;
      e_data  = (m_send && mq.size() > 0) ? mq[0].data : 32'd0;
      e_strb  = (m_send && mq.size() > 0) ? mq[0].strb : 4'd0;
      e_empty = (mq.size() == 0) && !m_send;
      chk("st_ready",     32'(st_ready),     32'(m_ready()));
      chk("mem_wr_valid", 32'(mem_wr_valid), 32'(m_send));
      chk("mem_wr_addr",  mem_wr_addr,       e_addr);
      chk("mem_wr_data",  mem_wr_data,       e_data);
      chk("mem_wr_strb",  32'(mem_wr_strb),  32'(e_strb));
      chk("empty",        32'(empty),        32'(e_empty));
      chk("busy",         32'(busy),         32'(!e_empty));
      if (mem_wr_valid && mem_wr_ready) begin
        lg.waddr = mem_wr_addr[31:2];
        lg.data  = mem_wr_data;
        lg.strb  = mem_wr_strb;
        wlog.push_back(lg);
      end
    end
    model_step();
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    st_valid = 1'b1;
    st_addr  = a;
    st_wdata = d;
    st_wstrb = s;
    step();
    st_valid = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (!empty && n < 200) begin
      step();
      n++;
    end
    chk({name, "_drained"}, 32'(empty), 32'd1);
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!mem_wr_valid && n < 100) begin
      step();
      n++;
    end
    chk({name, "_valid_seen"}, 32'(mem_wr_valid), 32'd1);
  endtask

  task automatic chk_wr(input string name, input int idx, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s);
    if (idx >= wlog.size()) begin
      checks++;
      failures++;
      $display("FAIL %s write %0d missing, only %0d writes seen", name, idx, wlog.size());
    end else begin
      chk({name, "_addr"}, {wlog[idx].waddr, 2'b00}, a);
      chk({name, "_data"}, wlog[idx].data, d);
      chk({name, "_strb"}, 32'(wlog[idx].strb), 32'(s));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int ph;
    int vprob [4] = '{60, 30, 5, 80};
    int rprob [4] = '{70, 30, 60, 20};

    rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_wdata = '0; st_wstrb = '0;
    drain_req = 1'b0; mem_wr_ready = 1'b0;
    step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("reset_st_ready", 32'(st_ready), 32'd1);
    chk("reset_valid",    32'(mem_wr_valid), 32'd0);
    chk("reset_addr",     mem_wr_addr, 32'd0);
    chk("reset_data",     mem_wr_data, 32'd0);
    chk("reset_strb",     32'(mem_wr_strb), 32'd0);
    chk("reset_empty",    32'(empty), 32'd1);
    chk("reset_busy",     32'(busy), 32'd0);

    // RGB565 pixel pair merges into one full-word write
    wlog.delete();
    mem_wr_ready = 1'b1;
    store(32'h1000, 32'h0000BEEF, 4'b0011);
    store(32'h1002, 32'hCAFE0000, 4'b1100);
    chk("model_rgb_count", 32'(mq.size()), 32'd1);
    chk("model_rgb_data", (mq.size() > 0) ? mq[0].data : 32'd0, 32'hCAFEBEEF);
    drain_req = 1'b1;
    wait_empty("rgb");
    drain_req = 1'b0;
    chk("rgb_nwrites", 32'(wlog.size()), 32'd1);
    chk_wr("rgb", 0, 32'h1000, 32'hCAFEBEEF, 4'hF);

    // Full backpressure: fifth new word stalls, merge still accepted
    wlog.delete();
    mem_wr_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      store(32'h3000 + 32'(4 * i), 32'h11111111 * 32'(i + 1), 4'hF);
    st_valid = 1'b1; st_addr = 32'h3010; st_wdata = 32'h99999999; st_wstrb = 4'hF;
    #1;
    chk("full_new_word_ready", 32'(st_ready), 32'd0);
    step();
    st_addr = 32'h3008; st_wdata = 32'h000000AA; st_wstrb = 4'b0001;
    #1;
    chk("full_merge_ready", 32'(st_ready), 32'd1);
    step();
    st_valid = 1'b0;
    mem_wr_ready = 1'b1;
    drain_req = 1'b1;
    wait_empty("full");
    drain_req = 1'b0;
    chk("full_nwrites", 32'(wlog.size()), 32'd4);
    chk_wr("full0", 0, 32'h3000, 32'h11111111, 4'hF);
    chk_wr("full1", 1, 32'h3004, 32'h22222222, 4'hF);
    chk_wr("full2", 2, 32'h3008, 32'h333333AA, 4'hF);
    chk_wr("full3", 3, 32'h300C, 32'h44444444, 4'hF);

    // Store to the locked head word allocates a second entry
    wlog.delete();
    mem_wr_ready = 1'b0;
    drain_req = 1'b1;
    store(32'h2000, 32'h11223344, 4'hF);
    wait_valid("lock");
    store(32'h2000, 32'h000000FF, 4'b0001);
    mem_wr_ready = 1'b1;
    wait_empty("lock");
    drain_req = 1'b0;
    chk("lock_nwrites", 32'(wlog.size()), 32'd2);
    chk_wr("lock0", 0, 32'h2000, 32'h11223344, 4'hF);
    chk_wr("lock1", 1, 32'h2000, 32'h000000FF, 4'b0001);

    // Idle timeout: single store, first write presented at cycle 17
    wlog.delete();
    mem_wr_ready = 1'b1;
    store(32'h12345670, 32'hA5A5A5A5, 4'hF);
    cyc = 1;
    while (!mem_wr_valid && cyc < 40) begin
      step();
      cyc++;
    end
    chk("idle_first_valid_cycle", 32'(cyc), 32'd17);
    wait_empty("idle");
    chk_wr("idle", 0, 32'h12345670, 32'hA5A5A5A5, 4'hF);

    // Full buffer with a pop in the same cycle still rejects a new word
    wlog.delete();
    mem_wr_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      store(32'h4000 + 32'(4 * i), 32'h0A0B0C00 + 32'(i), 4'hF);
    mem_wr_ready = 1'b1;
    st_valid = 1'b1; st_addr = 32'h5000; st_wdata = 32'h00000055; st_wstrb = 4'hF;
    #1;
    chk("simul_rejected", 32'(st_ready), 32'd0);
    step();
    chk("simul_next_ready", 32'(st_ready), 32'd1);
    step();
    st_valid = 1'b0;
    drain_req = 1'b1;
    wait_empty("simul");
    drain_req = 1'b0;
    chk("simul_nwrites", 32'(wlog.size()), 32'd5);
    chk_wr("simul0", 0, 32'h4000, 32'h0A0B0C00, 4'hF);
    chk_wr("simul4", 4, 32'h5000, 32'h00000055, 4'hF);

    // Reset while presenting drops everything
    wlog.delete();
    mem_wr_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      store(32'h6000 + 32'(4 * i), 32'h600D0000 + 32'(i), 4'hF);
    wait_valid("rstmid");
    rst = 1'b1;
    step();
    chk("rstmid_empty", 32'(empty), 32'd1);
    chk("rstmid_valid", 32'(mem_wr_valid), 32'd0);
    rst = 1'b0;
    mem_wr_ready = 1'b1;
    repeat (20) step();
    chk("rstmid_no_writes", 32'(wlog.size()), 32'd0);

    // Randomized traffic over a small address pool
    for (int c = 0; c < 3000; c++) begin
      ph = c / 750;
      st_valid     = ($urandom_range(0, 99) < vprob[ph]);
      st_addr      = 32'(32'h7000 + 4 * $urandom_range(0, 5) + $urandom_range(0, 3));
      st_wdata     = $urandom;
      st_wstrb     = 4'($urandom_range(0, 15));
      mem_wr_ready = ($urandom_range(0, 99) < rprob[ph]);
      drain_req    = ($urandom_range(0, 99) < 4);
      rst          = ($urandom_range(0, 999) == 0);
      step();
    end
    rst = 1'b0;
    st_valid = 1'b0;
    mem_wr_ready = 1'b1;
    drain_req = 1'b1;
    wait_empty("final");
    drain_req = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
